// File: rtl/fcvt_sched.sv
// Round-robin scheduler sharing one fixed-latency int/float conversion pipeline
// between two requesters, with credit-protected in-order response buffering.
module fcvt_sched #(
  parameter int LAT   = 2,
  parameter int DEPTH = 4,
  parameter int TAGW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic            req0_op,
  input  logic [31:0]     req0_x,
  input  logic [TAGW-1:0] req0_tag,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic            req1_op,
  input  logic [31:0]     req1_x,
  input  logic [TAGW-1:0] req1_tag,
  output logic [31:0]     conv_x,
  input  logic [31:0]     conv_sw_y,
  input  logic [31:0]     conv_ws_y,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_src,
  output logic [TAGW-1:0] resp_tag,
  output logic [31:0]     resp_y
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + LAT + 2);

  logic                ptr;
  logic [LAT:0]        trk_v;
  logic [LAT:0]        trk_op;
  logic [LAT:0]        trk_src;
  logic [TAGW-1:0]     trk_tag [LAT+1];

  logic [31:0]         fifo_y   [DEPTH];
  logic [TAGW-1:0]     fifo_tag [DEPTH];
  logic [DEPTH-1:0]    fifo_src;
  logic [PW-1:0]       rd_ptr;
  logic [PW-1:0]       wr_ptr;
  logic [OW-1:0]       cnt;
  logic [OW-1:0]       inflight;

  logic                can_issue;
  logic                accept;
  logic                win;
  logic                push;
  logic                pop;
  logic [31:0]         push_y;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i <= LAT; i++)
      inflight = inflight + OW'(trk_v[i]);
  end

  // Every accepted op lives either in the tracker or the FIFO, so this bounds FIFO fill.
  assign can_issue  = (inflight + cnt) < OW'(DEPTH);
  assign req0_ready = can_issue & ~rst & req0_valid & (~req1_valid | ~ptr);
  assign req1_ready = can_issue & ~rst & req1_valid & (~req0_valid | ptr);
  assign accept     = req0_ready | req1_ready;
  assign win        = req1_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= 1'b0;
      conv_x  <= '0;
      trk_v   <= '0;
      trk_op  <= '0;
      trk_src <= '0;
      for (int unsigned i = 0; i <= LAT; i++)
        trk_tag[i] <= '0;
    end else begin
      trk_v   <= {trk_v[LAT-1:0], accept};
      trk_op  <= {trk_op[LAT-1:0], win ? req1_op : req0_op};
      trk_src <= {trk_src[LAT-1:0], win};
      trk_tag[0] <= win ? req1_tag : req0_tag;
      for (int unsigned i = 1; i <= LAT; i++)
        trk_tag[i] <= trk_tag[i-1];
      if (accept) begin
        conv_x <= win ? req1_x : req0_x;
        ptr    <= ~win;
      end
    end
  end

  assign push   = trk_v[LAT];
  assign push_y = trk_op[LAT] ? conv_ws_y : conv_sw_y;
  assign pop    = resp_valid & resp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      fifo_src <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_y[i]   <= '0;
        fifo_tag[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_y[wr_ptr]   <= push_y;
        fifo_tag[wr_ptr] <= trk_tag[LAT];
        fifo_src[wr_ptr] <= trk_src[LAT];
        wr_ptr           <= nxt(wr_ptr);
      end
      if (pop)
        rd_ptr <= nxt(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign resp_valid = (cnt != '0);
  assign resp_src   = fifo_src[rd_ptr];
  assign resp_tag   = fifo_tag[rd_ptr];
  assign resp_y     = fifo_y[rd_ptr];

endmodule
